// File: rtl/speed_select_pkg.sv
`default_nettype none
// ============================================================================
// Module      : speed_select_pkg
// Description : Shared constants and types for the speed_select block and the
//               clock-divider stage that consumes its divisor. DIV_W is the
//               common divisor width on both sides of that interface.
// Revision    : 1.0 - initial release
// ============================================================================
package speed_select_pkg;

    localparam int DIV_W            = 28;

    // Board defaults: 50 MHz clock, 10 ms debounce, 0.5 s initial period.
    localparam int DEBOUNCE_DEF     = 500_000;
    localparam int DINIT_DEF        = 25_000_000;
    localparam int DSTEP_DEF        = 2_500_000;
    localparam int DMIN_DEF         = 2_500_000;
    localparam int DMAX_DEF         = 100_000_000;

    typedef logic [DIV_W-1:0] div_t;

    // Direction of a divisor update in a given cycle.
    typedef enum logic [1:0] {
        STEP_HOLD   = 2'd0,
        STEP_FASTER = 2'd1,
        STEP_SLOWER = 2'd2
    } step_e;

    // Two simultaneous presses cancel each other out.
    function automatic step_e step_decode(input logic faster, input logic slower);
        step_e step;
        case ({faster, slower})
            2'b10:   step = STEP_FASTER;
            2'b01:   step = STEP_SLOWER;
            default: step = STEP_HOLD;
        endcase
        return step;
    endfunction

endpackage : speed_select_pkg
`default_nettype wire

// File: rtl/speed_select_if.sv
`default_nettype none
// ============================================================================
// Module      : speed_select_if
// Description : Groups the push-button inputs and the divisor outputs of
//               speed_select.
//               master : the speed_select block (keys in, divisor out)
//               slave  : the environment (keys out, divisor in)
//               key_faster / key_slower : raw active-low buttons
//               dnew                    : registered divisor, DIV_W bits
//               at_min / at_max         : divisor sits on a limit
//               changed                 : one-cycle pulse on a new dnew
// Revision    : 1.0 - initial release
// ============================================================================
interface speed_select_if;
    import speed_select_pkg::*;

    logic key_faster;
    logic key_slower;
    div_t dnew;
    logic at_min;
    logic at_max;
    logic changed;

    modport master (
        input  key_faster,
        input  key_slower,
        output dnew,
        output at_min,
        output at_max,
        output changed
    );

    modport slave (
        output key_faster,
        output key_slower,
        input  dnew,
        input  at_min,
        input  at_max,
        input  changed
    );

endinterface : speed_select_if
`default_nettype wire

// File: rtl/speed_select_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Synchronises one raw active-low push-button, debounces it and
//               emits a registered single-cycle pulse on each accepted press.
//               clk, rst : system clock, synchronous active-high reset
//               i_key_n  : raw button, asynchronous, 0 = pressed
//               o_press  : one-cycle press event
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    // +1 keeps the width at least one bit when DEBOUNCE_CYCLES is 1.
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic [1:0]         r_vld;
    logic               r_armed;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_deb;
    logic               r_deb_q;
    logic               r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_deb   <= 1'b1;
            r_deb_q <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_meta <= i_key_n;
            r_sync <= r_meta;

            // r_vld[1] marks the point where r_sync reflects the real key
            // rather than its reset value. The key only arms once it has
            // been seen released, so a button held through reset cannot
            // produce a press until it is let go and pressed again.
            r_vld <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_sync) begin
                r_armed <= 1'b1;
            end

            if (r_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_deb <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            // Falling edge of the accepted level only; release is ignored.
            r_deb_q <= r_deb;
            r_press <= r_armed & r_deb_q & ~r_deb;
        end
    end

    assign o_press = r_press;

endmodule : key_debounce
`default_nettype wire

// File: rtl/speed_select.sv
`default_nettype none
// ============================================================================
// Module      : speed_select
// Description : Produces the divisor dnew for the taillight clock divider.
//               Debounced "faster"/"slower" button presses step the divisor
//               down/up by DSTEP, saturating at DMIN/DMAX.
//               clk, rst : system clock, synchronous active-high reset
//               bus      : speed_select_if.master (keys in; dnew, at_min,
//                          at_max, changed out - all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module speed_select
    import speed_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int DINIT           = DINIT_DEF,
    parameter int DSTEP           = DSTEP_DEF,
    parameter int DMIN            = DMIN_DEF,
    parameter int DMAX            = DMAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    speed_select_if.master   bus
);

    // Limits carried one bit wider than the divisor so that DMIN+DSTEP and
    // dnew+DSTEP can never wrap.
    localparam logic [DIV_W:0] c_INIT     = (DIV_W + 1)'(DINIT);
    localparam logic [DIV_W:0] c_STEP     = (DIV_W + 1)'(DSTEP);
    localparam logic [DIV_W:0] c_MIN      = (DIV_W + 1)'(DMIN);
    localparam logic [DIV_W:0] c_MAX      = (DIV_W + 1)'(DMAX);
    localparam logic [DIV_W:0] c_MIN_STEP = c_MIN + c_STEP;

    logic           w_press_faster;
    logic           w_press_slower;
    step_e          w_step;
    logic [DIV_W:0] w_dnew_wide;
    div_t           w_dnew_next;

    div_t           r_dnew;
    logic           r_changed;
    logic           r_at_min;
    logic           r_at_max;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_faster (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (bus.key_faster),
        .o_press (w_press_faster)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_slower (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (bus.key_slower),
        .o_press (w_press_slower)
    );

    assign w_step      = step_decode(w_press_faster, w_press_slower);
    assign w_dnew_wide = {1'b0, r_dnew};

    // dnew >= DMAX-DSTEP is evaluated as dnew+DSTEP >= DMAX so that a step
    // larger than DMAX cannot underflow the threshold.
    always_comb begin
        w_dnew_next = r_dnew;
        case (w_step)
            STEP_FASTER: begin
                if (w_dnew_wide <= c_MIN_STEP) begin
                    w_dnew_next = c_MIN[DIV_W-1:0];
                end else begin
                    w_dnew_next = r_dnew - c_STEP[DIV_W-1:0];
                end
            end
            STEP_SLOWER: begin
                if ((w_dnew_wide + c_STEP) >= c_MAX) begin
                    w_dnew_next = c_MAX[DIV_W-1:0];
                end else begin
                    w_dnew_next = r_dnew + c_STEP[DIV_W-1:0];
                end
            end
            default: w_dnew_next = r_dnew;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dnew    <= c_INIT[DIV_W-1:0];
            r_changed <= 1'b0;
            r_at_min  <= (c_INIT == c_MIN);
            r_at_max  <= (c_INIT == c_MAX);
        end else begin
            r_dnew    <= w_dnew_next;
            // A press while already on a limit yields no pulse.
            r_changed <= (w_dnew_next != r_dnew);
            r_at_min  <= (w_dnew_next == c_MIN[DIV_W-1:0]);
            r_at_max  <= (w_dnew_next == c_MAX[DIV_W-1:0]);
        end
    end

    assign bus.dnew    = r_dnew;
    assign bus.changed = r_changed;
    assign bus.at_min  = r_at_min;
    assign bus.at_max  = r_at_max;

endmodule : speed_select
`default_nettype wire

// File: tb/tb_speed_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_speed_select
// Description : Directed self-checking bench for speed_select with a short
//               debounce window (4 cycles) and small divisor limits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speed_select;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int DINIT           = 20;
    localparam int DSTEP           = 6;
    localparam int DMIN            = 4;
    localparam int DMAX            = 40;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;
    int n_chg   = 0;
    int n0;

    always #5 clk = ~clk;

    speed_select_if bus ();

    speed_select #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DINIT           (DINIT),
        .DSTEP           (DSTEP),
        .DMIN            (DMIN),
        .DMAX            (DMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Count changed pulses, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.changed === 1'b1) n_chg = n_chg + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.key_faster = 1'b1;
        bus.key_slower = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(3);
    endtask

    // Hold the selected key(s) low for 'hold' cycles, then release and let
    // the release debounce settle.
    task automatic press(input bit fast, input bit slow, input int hold);
        if (fast) bus.key_faster = 1'b0;
        if (slow) bus.key_slower = 1'b0;
        cycles(hold);
        bus.key_faster = 1'b1;
        bus.key_slower = 1'b1;
        cycles(12);
    endtask

    initial begin
        int exp_f [4] = '{14, 8, 4, 4};
        int exp_fm[4] = '{0, 0, 1, 1};
        int exp_fc[4] = '{1, 1, 1, 0};
        int exp_s [4] = '{26, 32, 38, 40};
        int exp_sm[4] = '{0, 0, 0, 1};

        rst            = 1'b1;
        bus.key_faster = 1'b1;
        bus.key_slower = 1'b1;
        cycles(3);
        check("rst_dnew",    bus.dnew,    20);
        check("rst_at_min",  bus.at_min,  0);
        check("rst_at_max",  bus.at_max,  0);
        check("rst_changed", bus.changed, 0);
        rst = 1'b0;
        cycles(5);
        check("idle_dnew", bus.dnew, 20);
        check("idle_chg",  n_chg,    0);

        // Clean press and hold: key falls before E0, update lands at E7.
        n0 = n_chg;
        bus.key_faster = 1'b0;
        cycles(7);
        check("clean_pre_dnew", bus.dnew,    20);
        check("clean_pre_chg",  bus.changed, 0);
        cycles(1);
        check("clean_dnew",    bus.dnew,    14);
        check("clean_changed", bus.changed, 1);
        cycles(1);
        check("clean_chg_drop", bus.changed, 0);
        cycles(20);
        check("hold_dnew",  bus.dnew,     14);
        check("hold_count", n_chg - n0,   1);
        bus.key_faster = 1'b1;
        cycles(12);
        check("release_dnew", bus.dnew, 14);

        // Bounce shorter than the debounce window is ignored.
        do_reset();
        n0 = n_chg;
        bus.key_slower = 1'b0; cycles(3);
        bus.key_slower = 1'b1; cycles(1);
        bus.key_slower = 1'b0; cycles(3);
        bus.key_slower = 1'b1; cycles(12);
        check("bounce_dnew",  bus.dnew,   20);
        check("bounce_count", n_chg - n0, 0);
        press(1'b0, 1'b1, 10);
        check("bounce_press_dnew",  bus.dnew,   26);
        check("bounce_press_count", n_chg - n0, 1);

        // Saturation toward DMIN.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n0 = n_chg;
            press(1'b1, 1'b0, 10);
            check($sformatf("fast%0d_dnew", i),   bus.dnew,   exp_f[i]);
            check($sformatf("fast%0d_at_min", i), bus.at_min, exp_fm[i]);
            check($sformatf("fast%0d_chg", i),    n_chg - n0, exp_fc[i]);
        end

        // Saturation toward DMAX.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n0 = n_chg;
            press(1'b0, 1'b1, 10);
            check($sformatf("slow%0d_dnew", i),   bus.dnew,   exp_s[i]);
            check($sformatf("slow%0d_at_max", i), bus.at_max, exp_sm[i]);
            check($sformatf("slow%0d_chg", i),    n_chg - n0, 1);
        end

        // Both keys on the same cycle cancel.
        do_reset();
        n0 = n_chg;
        press(1'b1, 1'b1, 10);
        check("both_dnew",  bus.dnew,   20);
        check("both_count", n_chg - n0, 0);

        // Reset sampled at E5, two edges before the pending update at E7,
        // with the key held through and beyond reset.
        do_reset();
        n0 = n_chg;
        bus.key_faster = 1'b0;
        cycles(5);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(30);
        check("midrst_dnew",  bus.dnew,   20);
        check("midrst_count", n_chg - n0, 0);
        bus.key_faster = 1'b1;
        cycles(12);
        check("held_release_dnew",  bus.dnew,   20);
        check("held_release_count", n_chg - n0, 0);
        press(1'b1, 1'b0, 10);
        check("repress_dnew",  bus.dnew,   14);
        check("repress_count", n_chg - n0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_speed_select
`default_nettype wire

// File: doc/speed_select.md
# speed_select

Generates the 28-bit divisor `dnew` consumed by the clock-divider stage of the ThunderBird taillight design, so it sits on the producer side of that interface. Two push-buttons raise or lower the sequencing frequency. Each button is synchronised and debounced, then converted to a single-cycle press event. Each press steps the divisor by a fixed amount, with saturation at configured limits. A smaller `dnew` gives a faster output clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); must be ≥1.
- `DINIT`, 25_000_000: divisor loaded at reset.
- `DSTEP`, 2_500_000: divisor change per press; must be ≥1.
- `DMIN`, 2_500_000: lowest divisor, i.e. fastest output; must be ≥2.
- `DMAX`, 100_000_000: highest divisor, i.e. slowest output; must be ≤2^28−1.
- Required ordering: DMIN ≤ DINIT ≤ DMAX.

Ports:
- `clk` in 1: system clock (50 MHz board clock).
- `rst` in 1: synchronous, active-high reset.
- `key_faster` in 1: raw active-low push-button (0 = pressed), asynchronous to `clk`.
- `key_slower` in 1: raw active-low push-button (0 = pressed), asynchronous to `clk`.
- `dnew` out 28: current divisor, registered.
- `at_min` out 1: high when `dnew == DMIN`; registered.
- `at_max` out 1: high when `dnew == DMAX`; registered.
- `changed` out 1: one-cycle pulse on the cycle `dnew` takes a new value.

## Operation
Per-key path:
- Two-flop synchroniser, reset value 1 (released).
- Debounce counter and accepted level `deb`, reset value 1.
  - While the synchronised level equals `deb`, the counter holds at 0.
  - While it differs, the counter increments.
  - When the count reaches DEBOUNCE_CYCLES−1 with the level still differing, `deb` takes the new level and the counter clears.
  - Any return to `deb` before that clears the counter. A glitch shorter than DEBOUNCE_CYCLES never changes `deb`.
- Press event: registered one-cycle pulse on the 1→0 transition of `deb`. Release generates nothing. Holding a key gives exactly one event; there is no auto-repeat.

Divisor update, evaluated in the cycle after a press pulse:
- Faster only: if `dnew ≤ DMIN + DSTEP`, set `dnew = DMIN`; otherwise `dnew = dnew − DSTEP`.
- Slower only: if `dnew ≥ DMAX − DSTEP`, set `dnew = DMAX`; otherwise `dnew = dnew + DSTEP`.
- Both pulses in the same cycle: no change, and `changed` stays 0.
- Comparisons are made in 29 bits, so no intermediate wraps.
- `changed` pulses only if the value actually differs. A press while already at the limit leaves `changed` at 0.
- `at_min` and `at_max` are registered from the next `dnew` value and update on the same edge as `dnew`.

Reset (synchronous, overrides everything, takes effect at any point mid-debounce):
- `dnew = DINIT`.
- `changed = 0`.
- `at_min = (DINIT == DMIN)`, `at_max = (DINIT == DMAX)`.
- All synchronisers, `deb`, and counters released/cleared.
- A key held through reset deassertion produces no press event until it is released and pressed again.

## Timing
Raw key falls before edge E0. Let D = DEBOUNCE_CYCLES.
- Synchroniser output low after edge E1.
- `deb` falls at edge E1+D.
- Press pulse high for the cycle after edge E2+D.
- `dnew`, `changed`, `at_min`, `at_max` update at edge E3+D.
- Total latency is D+3 edges; `changed` is high for exactly one cycle.
- Back-to-back presses on one key are separated by at least 2·D cycles because of debounce on release and on re-press. Presses on the two keys are independent.
- `dnew` is stable between updates. The downstream divider samples it freely with no handshake.

## Structure
- Shared package constants: `DIV_W = 28` and default values DINIT, DMIN, DMAX, DSTEP. The divider and this block use the same width constant.
- One sub-module `key_debounce` (synchroniser, debounce counter, press-pulse register; parameter DEBOUNCE_CYCLES), instantiated twice.
- The top level holds the divisor register, saturation arithmetic and flags.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, DINIT=20, DSTEP=6, DMIN=4, DMAX=40.
- Reset, no keys:
  - `dnew=20`, `at_min=0`, `at_max=0`, `changed=0`.
- Clean press and hold of `key_faster`:
  - `dnew=14` exactly 7 edges after the fall.
  - `changed` high one cycle.
  - No further change while held.
- Key bounce:
  - `key_slower` bounces low 3 cycles / high 1 / low 3, then releases → no change.
  - A subsequent 10-cycle low gives `dnew=26`.
- Saturation:
  - Four `key_faster` presses from 20 → 14, 8, 4, 4.
  - `at_min=1` after the third press; `changed` absent on the fourth.
  - From 20, four `key_slower` presses → 26, 32, 38, 40, then `at_max=1`.
- Simultaneous presses: both keys fall on the same cycle → `dnew` unchanged, `changed=0`.
- Reset mid-operation:
  - Assert `rst` two cycles before a pending update → `dnew=20`, no pulse.
  - A key held through reset causes no change until it is released and re-pressed.
